// File: rtl/mem_responder_if.sv
// Bus bundle between the memory responder and its clients: CPU memory port,
// boot-loader valid/ready port and the I/O page pins.
interface mem_responder_if;
    logic       memEnable;
    logic [7:0] memAdr;
    logic [7:0] memWD;
    logic [7:0] memRD;
    logic       ldValid;
    logic       ldReady;
    logic [7:0] ldAddr;
    logic [7:0] ldData;
    logic       ldDone;
    logic       cpuHold;
    logic [7:0] outPort;
    logic       outStrobe;
    logic [7:0] inPort;

    // CPU / loader / environment side
    modport master (
        output memEnable, memAdr, memWD, ldValid, ldAddr, ldData, ldDone, inPort,
        input  memRD, ldReady, cpuHold, outPort, outStrobe
    );

    // Responder side
    modport slave (
        input  memEnable, memAdr, memWD, ldValid, ldAddr, ldData, ldDone, inPort,
        output memRD, ldReady, cpuHold, outPort, outStrobe
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder for the 8-bit multicycle CPU. Holds the CPU in reset
// while a boot loader fills RAM, then serves CPU reads/writes to RAM and to a
// 4-register I/O page (output latch, synchronized input, tick counter, strobe).
module mem_responder #(
    parameter int         RAM_DEPTH   = 240,
    parameter logic [7:0] IO_BASE     = 8'hF0,
    parameter int         SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);

    localparam int         AW      = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [7:0] RAM_TOP = 8'(RAM_DEPTH);
    localparam logic [7:0] IO_OUT  = IO_BASE;
    localparam logic [7:0] IO_IN   = IO_BASE + 8'd1;
    localparam logic [7:0] IO_TICK = IO_BASE + 8'd2;
    localparam logic [7:0] IO_STAT = IO_BASE + 8'd3;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                       state_r;
    logic                         cpu_hold_r;
    logic                         ld_ready_r;
    logic [7:0]                   out_port_r;
    logic                         out_strobe_r;
    logic [7:0]                   tick_r;
    logic [SYNC_STAGES-1:0][7:0]  sync_r;
    logic [7:0]                   ram_r [RAM_DEPTH];

    logic                         run_s;
    logic                         cpu_ram_we_s;
    logic                         ld_ram_we_s;
    logic                         wr_out_s;
    logic                         wr_tick_s;
    logic [7:0]                   rd_s;

    // Write-strobe decode for RAM and the writable I/O registers
    always_comb begin
        run_s        = (state_r == ST_RUN);
        cpu_ram_we_s = 1'b0;
        ld_ram_we_s  = 1'b0;
        wr_out_s     = 1'b0;
        wr_tick_s    = 1'b0;
        if (run_s) begin
            cpu_ram_we_s = bus.memEnable && (bus.memAdr < RAM_TOP);
            wr_out_s     = bus.memEnable && (bus.memAdr == IO_OUT);
            wr_tick_s    = bus.memEnable && (bus.memAdr == IO_TICK);
        end else begin
            // Out-of-range loader bytes are handshaken but never stored
            ld_ram_we_s  = bus.ldValid && ld_ready_r && (bus.ldAddr < RAM_TOP);
        end
    end

    // Control FSM with registered handshake, hold and I/O register outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_LOAD;
            cpu_hold_r   <= 1'b1;
            ld_ready_r   <= 1'b1;
            out_port_r   <= 8'h00;
            out_strobe_r <= 1'b0;
            tick_r       <= 8'h00;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    out_strobe_r <= 1'b0;
                    tick_r       <= 8'h00;
                    if (bus.ldDone) begin
                        state_r    <= ST_RUN;
                        cpu_hold_r <= 1'b0;
                        ld_ready_r <= 1'b0;
                    end else begin
                        state_r    <= ST_LOAD;
                        cpu_hold_r <= 1'b1;
                        ld_ready_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Only reset leaves RUN; a late ldDone is ignored here
                    state_r      <= ST_RUN;
                    cpu_hold_r   <= 1'b0;
                    ld_ready_r   <= 1'b0;
                    out_strobe_r <= wr_out_s;
                    if (wr_out_s) begin
                        out_port_r <= bus.memWD;
                    end
                    // A CPU load of the counter wins over that edge's increment
                    if (wr_tick_s) begin
                        tick_r <= bus.memWD;
                    end else begin
                        tick_r <= tick_r + 8'd1;
                    end
                end
                default: begin
                    state_r      <= ST_LOAD;
                    cpu_hold_r   <= 1'b1;
                    ld_ready_r   <= 1'b1;
                    out_strobe_r <= 1'b0;
                    tick_r       <= 8'h00;
                end
            endcase
        end
    end

    // Input synchronizer chain; the last stage is what the CPU reads
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r <= {SYNC_STAGES{8'h00}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], bus.inPort};
        end
    end

    // RAM array, intentionally not reset so contents survive a reload cycle
    always_ff @(posedge clk) begin
        if (ld_ram_we_s) begin
            ram_r[bus.ldAddr[AW-1:0]] <= bus.ldData;
        end else if (cpu_ram_we_s) begin
            ram_r[bus.memAdr[AW-1:0]] <= bus.memWD;
        end
    end

    // Zero-latency read mux; nothing is visible to the CPU while loading
    always_comb begin
        rd_s = 8'h00;
        if (run_s) begin
            if (bus.memAdr < RAM_TOP) begin
                rd_s = ram_r[bus.memAdr[AW-1:0]];
            end else begin
                case (bus.memAdr)
                    IO_OUT:  rd_s = out_port_r;
                    IO_IN:   rd_s = sync_r[SYNC_STAGES-1];
                    IO_TICK: rd_s = tick_r;
                    IO_STAT: rd_s = {7'b0000000, out_strobe_r};
                    default: rd_s = 8'h00;
                endcase
            end
        end else begin
            rd_s = 8'h00;
        end
    end

    assign bus.memRD     = rd_s;
    assign bus.ldReady   = ld_ready_r;
    assign bus.cpuHold   = cpu_hold_r;
    assign bus.outPort   = out_port_r;
    assign bus.outStrobe = out_strobe_r;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: stimulus pushes expected values into a
// queue, a negedge monitor pops each entry and compares it to the DUT.
module tb_mem_responder;

    localparam int SEL_RD     = 0;
    localparam int SEL_HOLD   = 1;
    localparam int SEL_READY  = 2;
    localparam int SEL_OUT    = 3;
    localparam int SEL_STROBE = 4;

    typedef struct {
        string      name;
        int         sel;
        logic [7:0] exp;
    } chk_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;
    chk_t q[$];
    chk_t mon_c;
    logic [7:0] mon_act;

    mem_responder_if bus ();

    mem_responder #(
        .RAM_DEPTH  (240),
        .IO_BASE    (8'hF0),
        .SYNC_STAGES(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] observe(input int sel);
        case (sel)
            SEL_RD:     return bus.memRD;
            SEL_HOLD:   return {7'b0000000, bus.cpuHold};
            SEL_READY:  return {7'b0000000, bus.ldReady};
            SEL_OUT:    return bus.outPort;
            SEL_STROBE: return {7'b0000000, bus.outStrobe};
            default:    return 8'hXX;
        endcase
    endfunction

    // Monitor: drain every pending expectation mid-cycle
    always @(negedge clk) begin
        while (q.size() != 0) begin
            mon_c   = q.pop_front();
            mon_act = observe(mon_c.sel);
            n_vec++;
            if (mon_act !== mon_c.exp) begin
                n_bad++;
                $display("FAIL %s: got %02h, expected %02h", mon_c.name, mon_act, mon_c.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_sig(input string name, input int sel, input logic [7:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        q.push_back(c);
    endtask

    task automatic cpu(input logic en, input logic [7:0] adr, input logic [7:0] wd);
        bus.memEnable = en;
        bus.memAdr    = adr;
        bus.memWD     = wd;
    endtask

    task automatic ldr(input logic v, input logic [7:0] a, input logic [7:0] d, input logic done);
        bus.ldValid = v;
        bus.ldAddr  = a;
        bus.ldData  = d;
        bus.ldDone  = done;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b0;
        bus.inPort = 8'h00;
        cpu(1'b0, 8'h00, 8'h00);
        ldr(1'b0, 8'h00, 8'h00, 1'b0);
        repeat (2) step();

        // Reset state
        expect_sig("rst_hold",   SEL_HOLD,   8'h01);
        expect_sig("rst_ready",  SEL_READY,  8'h01);
        expect_sig("rst_out",    SEL_OUT,    8'h00);
        expect_sig("rst_strobe", SEL_STROBE, 8'h00);
        expect_sig("rst_rd",     SEL_RD,     8'h00);
        step();
        reset = 1'b1;
        step();

        // LOAD: preload 0x20, then a CPU write in LOAD must be ignored
        ldr(1'b1, 8'h20, 8'h42, 1'b0);
        expect_sig("load_hold", SEL_HOLD, 8'h01);
        step();
        ldr(1'b0, 8'h00, 8'h00, 1'b0);
        cpu(1'b1, 8'h20, 8'hFF);
        expect_sig("load_cpu_rd", SEL_RD, 8'h00);
        step();
        cpu(1'b0, 8'h00, 8'h00);
        ldr(1'b1, 8'h00, 8'h3C, 1'b0);
        step();
        ldr(1'b1, 8'hEF, 8'h11, 1'b0);
        step();
        ldr(1'b1, 8'hF0, 8'h99, 1'b1);
        expect_sig("pre_done_hold", SEL_HOLD, 8'h01);
        step();

        // RUN entered
        ldr(1'b0, 8'h00, 8'h00, 1'b0);
        expect_sig("run_hold",  SEL_HOLD,  8'h00);
        expect_sig("run_ready", SEL_READY, 8'h00);
        expect_sig("run_out",   SEL_OUT,   8'h00);
        cpu(1'b0, 8'h00, 8'h00); expect_sig("rd_00", SEL_RD, 8'h3C); step();
        cpu(1'b0, 8'hEF, 8'h00); expect_sig("rd_ef", SEL_RD, 8'h11); step();
        cpu(1'b0, 8'h20, 8'h00); expect_sig("rd_20", SEL_RD, 8'h42); step();
        cpu(1'b0, 8'hF5, 8'h00); expect_sig("rd_f5", SEL_RD, 8'h00); step();

        // Write-first at the edge, old value before it
        cpu(1'b1, 8'h00, 8'h77); expect_sig("wf_old", SEL_RD, 8'h3C); step();
        cpu(1'b0, 8'h00, 8'h00); expect_sig("wf_new", SEL_RD, 8'h77); step();

        // Back-to-back outPort writes
        cpu(1'b1, 8'hF0, 8'hA5);
        step();
        expect_sig("strobe_1", SEL_STROBE, 8'h01);
        expect_sig("outport",  SEL_OUT,    8'hA5);
        expect_sig("rd_f0",    SEL_RD,     8'hA5);
        step();
        cpu(1'b0, 8'hF3, 8'h00);
        expect_sig("strobe_2", SEL_STROBE, 8'h01);
        expect_sig("rd_f3_hi", SEL_RD,     8'h01);
        step();
        expect_sig("strobe_3", SEL_STROBE, 8'h00);
        expect_sig("rd_f3_lo", SEL_RD,     8'h00);
        step();

        // Tick load and wrap
        cpu(1'b1, 8'hF2, 8'hFE); step();
        cpu(1'b0, 8'hF2, 8'h00); expect_sig("tick_fe", SEL_RD, 8'hFE); step();
        expect_sig("tick_ff", SEL_RD, 8'hFF); step();
        expect_sig("tick_00", SEL_RD, 8'h00); step();
        expect_sig("tick_01", SEL_RD, 8'h01); step();
        cpu(1'b1, 8'hF1, 8'h33); step();
        cpu(1'b1, 8'hF3, 8'h33); step();
        cpu(1'b1, 8'hF8, 8'h33); step();
        cpu(1'b0, 8'hF2, 8'h00); expect_sig("tick_05", SEL_RD, 8'h05); step();
        cpu(1'b0, 8'hF0, 8'h00);
        expect_sig("ign_out",    SEL_RD,     8'hA5);
        expect_sig("ign_strobe", SEL_STROBE, 8'h00);
        step();
        cpu(1'b0, 8'hF1, 8'h00); expect_sig("in_before", SEL_RD, 8'h00);

        // inPort synchronizer latency, change mid-cycle
        #2;
        bus.inPort = 8'h7E;
        step();
        expect_sig("in_edge1", SEL_RD, 8'h00);
        step();
        expect_sig("in_edge2", SEL_RD, 8'h7E);
        step();

        // RAM write, then ldDone in RUN has no effect
        cpu(1'b1, 8'h10, 8'h5A); step();
        cpu(1'b0, 8'h10, 8'h00); expect_sig("rd_10", SEL_RD, 8'h5A); step();
        ldr(1'b1, 8'h10, 8'h00, 1'b1); step();
        ldr(1'b0, 8'h00, 8'h00, 1'b0);
        expect_sig("late_done_hold", SEL_HOLD, 8'h00);
        expect_sig("late_done_rd",   SEL_RD,   8'h5A);
        step();

        // Reset mid-RUN, RAM survives a reload
        cpu(1'b0, 8'hF2, 8'h00);
        reset = 1'b0;
        expect_sig("rr_hold",  SEL_HOLD,  8'h01);
        expect_sig("rr_ready", SEL_READY, 8'h01);
        expect_sig("rr_out",   SEL_OUT,   8'h00);
        expect_sig("rr_rd",    SEL_RD,    8'h00);
        step();
        reset = 1'b1;
        step();
        ldr(1'b1, 8'h30, 8'h66, 1'b1); step();
        ldr(1'b0, 8'h00, 8'h00, 1'b0);
        expect_sig("rr_tick", SEL_RD,   8'h00);
        expect_sig("rr_run",  SEL_HOLD, 8'h00);
        step();
        cpu(1'b0, 8'h10, 8'h00); expect_sig("rr_rd_10", SEL_RD, 8'h5A); step();
        cpu(1'b0, 8'h30, 8'h00); expect_sig("rr_rd_30", SEL_RD, 8'h66); step();
        cpu(1'b0, 8'h00, 8'h00); expect_sig("rr_rd_00", SEL_RD, 8'h77); step();

        for (int i = 0; i < 10 && q.size() != 0; i++) step();
        if (q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: got %0d pending checks, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
